// File: rtl/hps_spi_pkg.sv
// Shared definitions for the HPS-to-fabric SPI configuration slave.
package hps_spi_pkg;

    localparam int FRAME_BITS = 16;
    localparam int RW_BIT     = 15;
    localparam int CNT_W      = 4;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        RD,
        WR,
        DONE
    } state_e;

endpackage

// File: rtl/hps_spi_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pad, plus an edge detector
// producing single-cycle rise/fall pulses in the system clock domain.
module hps_spi_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;

    // NOTE: these flops are deliberately not reset; they keep tracking the pad
    // through RST so a pad that is already low cannot fake an edge on release.
    always_ff @(posedge clk_i) begin
        sync_q[0] <= async_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
        end
        edge_q <= sync_q[SYNC_STAGES-1];
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~edge_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] & edge_q;

endmodule

// File: rtl/hps_spi_cfg_slave.sv
// SPI mode-0 slave decoding 16-bit register frames (R/W, address, data) from
// the HPS into a single-cycle register bus for the camera configuration file.
module hps_spi_cfg_slave
    import hps_spi_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SPIM_CLK,
    input  logic              SPIM_SS,
    input  logic              SPIM_MOSI,
    output logic              SPIM_MISO,
    output logic              SPIM_MISO_OE,
    output logic [ADDR_W-1:0] REG_ADDR,
    output logic [DATA_W-1:0] REG_WDATA,
    output logic              REG_WE,
    output logic              REG_RE,
    input  logic [DATA_W-1:0] REG_RDATA,
    output logic              FRAME_ERR
);

    localparam logic [CNT_W-1:0] LAST_CMD_CNT = CNT_W'(FRAME_BITS - DATA_W - 1);
    localparam logic [CNT_W-1:0] LAST_BIT_CNT = CNT_W'(FRAME_BITS - 1);
    localparam int               RW_POS       = RW_BIT - DATA_W;

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic ss_lvl, ss_rise, ss_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    hps_spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk_i   (CLK),
        .async_i (SPIM_CLK),
        .level_o (sclk_lvl),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    hps_spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
        .clk_i   (CLK),
        .async_i (SPIM_SS),
        .level_o (ss_lvl),
        .rise_o  (ss_rise),
        .fall_o  (ss_fall)
    );

    hps_spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk_i   (CLK),
        .async_i (SPIM_MOSI),
        .level_o (mosi_lvl),
        .rise_o  (mosi_rise),
        .fall_o  (mosi_fall)
    );

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d, shift_in;
    logic [DATA_W-1:0]     tx_q, tx_d;
    logic                  miso_q, miso_d;
    logic                  oe_q;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  re_q, re_d;
    logic                  rd_cap_q;
    logic                  err_q, err_d;
    logic                  frame_last;
    logic                  unused_sigs;

    assign shift_in    = {shift_q[FRAME_BITS-2:0], mosi_lvl};
    assign frame_last  = sclk_rise && (cnt_q == LAST_BIT_CNT);
    assign unused_sigs = ^{sclk_lvl, mosi_rise, mosi_fall, shift_q[FRAME_BITS-1]};

    // NOTE: every next-state signal takes its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        miso_d  = miso_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        re_d    = 1'b0;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (ss_fall) begin
                    state_d = CMD;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            CMD: begin
                miso_d = 1'b0;
                if (sclk_rise) begin
                    shift_d = shift_in;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_CMD_CNT) begin
                        addr_d = shift_in[ADDR_W-1:0];
                        if (shift_in[RW_POS]) begin
                            state_d = WR;
                        end else begin
                            re_d    = 1'b1;
                            state_d = RD;
                        end
                    end
                end
                if (ss_rise) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    re_d    = 1'b0;
                end
            end
            RD: begin
                if (rd_cap_q) begin
                    tx_d = REG_RDATA;
                end
                // The first fall seen here is the 8th, so bit 7 leads.
                if (sclk_fall) begin
                    miso_d = tx_q[DATA_W-1];
                    tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                end
                if (sclk_rise) begin
                    shift_d = shift_in;
                    cnt_d   = cnt_q + 1'b1;
                    if (frame_last) begin
                        state_d = DONE;
                        miso_d  = 1'b0;
                    end
                end
                if (ss_rise) begin
                    state_d = IDLE;
                    miso_d  = 1'b0;
                    if (!frame_last) begin
                        err_d = 1'b1;
                    end
                end
            end
            WR: begin
                if (sclk_rise) begin
                    shift_d = shift_in;
                    cnt_d   = cnt_q + 1'b1;
                    if (frame_last) begin
                        wdata_d = shift_in[DATA_W-1:0];
                        we_d    = 1'b1;
                        state_d = DONE;
                    end
                end
                if (ss_rise) begin
                    state_d = IDLE;
                    if (!frame_last) begin
                        err_d = 1'b1;
                    end
                end
            end
            DONE: begin
                miso_d = 1'b0;
                if (ss_rise) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            tx_q     <= '0;
            miso_q   <= 1'b0;
            oe_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
            rd_cap_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            miso_q   <= miso_d;
            oe_q     <= ~ss_lvl;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            re_q     <= re_d;
            rd_cap_q <= re_q;
            err_q    <= err_d;
        end
    end

    assign SPIM_MISO    = miso_q;
    assign SPIM_MISO_OE = oe_q;
    assign REG_ADDR     = addr_q;
    assign REG_WDATA    = wdata_q;
    assign REG_WE       = we_q;
    assign REG_RE       = re_q;
    assign FRAME_ERR    = err_q;

endmodule
